// File: rtl/seg_scan_driver.sv
// Memory-mapped multiplexed seven-segment driver: DATA/CTRL registers, prescaled digit scan,
// anti-ghosting blank window, leading-zero blanking and per-digit enable/dp, with readback.
module seg_scan_driver #(
   parameter int DIGITS     = 8,
   parameter int DIV        = 100000,
   parameter int BLANK      = 8,
   parameter int ACTIVE_LOW = 1
) (
   input  logic              CLK,
   input  logic              Reset,
   input  logic              WE,
   input  logic [1:0]        ADDR,
   input  logic [31:0]       WD,
   output logic [31:0]       RD,
   output logic [DIGITS-1:0] AN,
   output logic [7:0]        SEG
);

   localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
   localparam logic [CW-1:0] BLANK_C  = CW'(BLANK);
   localparam logic [2:0]    IDX_LAST = 3'(DIGITS - 1);

   localparam logic [DIGITS-1:0] AN_OFF  = (ACTIVE_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};
   localparam logic [7:0]        SEG_OFF = (ACTIVE_LOW != 0) ? 8'hFF : 8'h00;

   localparam logic [1:0] A_DATA = 2'd0;
   localparam logic [1:0] A_CTRL = 2'd1;
   localparam logic [1:0] A_STAT = 2'd2;

   localparam logic [16:0] CTRL_RST = 17'h000FF;

   logic [31:0]       data_q, data_d;
   logic [16:0]       ctrl_q, ctrl_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [2:0]        idx_q, idx_d;
   logic [DIGITS-1:0] an_q, an_d;
   logic [7:0]        seg_q, seg_d;

   logic [7:0]        en_s;
   logic [7:0]        dp_s;
   logic              lzb_s;
   logic [7:0]        lz_s;
   logic              lz_run_s;
   logic [3:0]        nib_s;
   logic              blank_s;
   logic [DIGITS-1:0] an_act_s;

   // Hex digit to active-high {g,f,e,d,c,b,a}.
   function automatic logic [6:0] hex7(input logic [3:0] n);
      logic [6:0] p;
      case (n)
         4'h0:    p = 7'h3F;
         4'h1:    p = 7'h06;
         4'h2:    p = 7'h5B;
         4'h3:    p = 7'h4F;
         4'h4:    p = 7'h66;
         4'h5:    p = 7'h6D;
         4'h6:    p = 7'h7D;
         4'h7:    p = 7'h07;
         4'h8:    p = 7'h7F;
         4'h9:    p = 7'h6F;
         4'hA:    p = 7'h77;
         4'hB:    p = 7'h7C;
         4'hC:    p = 7'h39;
         4'hD:    p = 7'h5E;
         4'hE:    p = 7'h79;
         4'hF:    p = 7'h71;
         default: p = 7'h00;
      endcase
      return p;
   endfunction

   assign en_s  = ctrl_q[7:0];
   assign dp_s  = ctrl_q[15:8];
   assign lzb_s = ctrl_q[16];
   assign nib_s = data_q[{idx_q, 2'b00} +: 4];

   // lz_s[i] is set when nibbles i..DIGITS-1 are all zero.
   always_comb begin
      lz_s     = 8'h00;
      lz_run_s = 1'b1;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         lz_run_s = lz_run_s & (data_q[4*i +: 4] == 4'h0);
         lz_s[i]  = lz_run_s;
      end
   end

   // One-hot digit select, before polarity.
   always_comb begin
      an_act_s = {DIGITS{1'b0}};
      for (int i = 0; i < DIGITS; i++) begin
         an_act_s[i] = (idx_q == 3'(i));
      end
   end

   // Blank window, disabled digit, or suppressed leading zero (dp goes dark with it).
   always_comb begin
      if (cnt_q < BLANK_C) begin
         blank_s = 1'b1;
      end else if (!en_s[idx_q]) begin
         blank_s = 1'b1;
      end else if (lzb_s && (idx_q != 3'd0) && lz_s[idx_q]) begin
         blank_s = 1'b1;
      end else begin
         blank_s = 1'b0;
      end
   end

   // Output register next state; XOR with the off value applies the polarity.
   always_comb begin
      if (blank_s) begin
         an_d  = AN_OFF;
         seg_d = SEG_OFF;
      end else begin
         an_d  = an_act_s ^ AN_OFF;
         seg_d = {dp_s[idx_q], hex7(nib_s)} ^ SEG_OFF;
      end
   end

   // Prescaler and digit index.
   always_comb begin
      if (cnt_q == CNT_LAST) begin
         cnt_d = {CW{1'b0}};
         if (idx_q == IDX_LAST) begin
            idx_d = 3'd0;
         end else begin
            idx_d = idx_q + 3'd1;
         end
      end else begin
         cnt_d = cnt_q + CW'(1);
         idx_d = idx_q;
      end
   end

   // Register writes from the store path; STATUS and reserved are not writable.
   always_comb begin
      data_d = data_q;
      ctrl_d = ctrl_q;
      if (WE && (ADDR == A_DATA)) begin
         data_d = WD;
      end else if (WE && (ADDR == A_CTRL)) begin
         ctrl_d = WD[16:0];
      end else begin
         data_d = data_q;
      end
   end

   // Combinational readback.
   always_comb begin
      case (ADDR)
         A_DATA:  RD = data_q;
         A_CTRL:  RD = {15'h0000, ctrl_q};
         A_STAT:  RD = {29'h00000000, idx_q};
         default: RD = 32'h00000000;
      endcase
   end

   // State and output registers.
   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         data_q <= 32'h00000000;
         ctrl_q <= CTRL_RST;
         cnt_q  <= {CW{1'b0}};
         idx_q  <= 3'd0;
         an_q   <= AN_OFF;
         seg_q  <= SEG_OFF;
      end else begin
         data_q <= data_d;
         ctrl_q <= ctrl_d;
         cnt_q  <= cnt_d;
         idx_q  <= idx_d;
         an_q   <= an_d;
         seg_q  <= seg_d;
      end
   end

   assign AN  = an_q;
   assign SEG = seg_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Scoreboard bench for seg_scan_driver: stimulus pushes hand-computed expectations per cycle,
// a monitor pops and compares after each clock edge (or after an asynchronous reset event).
module tb_seg_scan_driver;

   logic CLK = 1'b0;
   always #5 CLK = ~CLK;

   logic        Reset;
   logic        we_a, we_b;
   logic [1:0]  addr_a, addr_b;
   logic [31:0] wd_a, wd_b, rd_a, rd_b;
   logic [3:0]  an_a;
   logic [7:0]  an_b;
   logic [7:0]  seg_a, seg_b;

   seg_scan_driver #(.DIGITS(4), .DIV(4), .BLANK(1), .ACTIVE_LOW(1)) dut_a (
      .CLK(CLK), .Reset(Reset), .WE(we_a), .ADDR(addr_a), .WD(wd_a),
      .RD(rd_a), .AN(an_a), .SEG(seg_a));

   seg_scan_driver #(.DIGITS(8), .DIV(4), .BLANK(1), .ACTIVE_LOW(0)) dut_b (
      .CLK(CLK), .Reset(Reset), .WE(we_b), .ADDR(addr_b), .WD(wd_b),
      .RD(rd_b), .AN(an_b), .SEG(seg_b));

   typedef struct {
      int          kind;
      logic [7:0]  an;
      logic [7:0]  seg;
      logic [31:0] rd;
      string       tag;
   } exp_t;

   exp_t sb_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   event mon_ev;

   logic [7:0]  a_seg[4];
   logic [3:0]  a_on;
   logic [7:0]  b_seg[8];
   int          ph;
   logic        we_b_next;
   logic [31:0] wd_b_next;

   // Monitor: drain every expectation queued for this sample point.
   initial begin
      exp_t e;
      forever begin
         @(posedge CLK or mon_ev);
         #1;
         while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            case (e.kind)
               1: begin
                  n_cmp++;
                  if ({4'h0, an_a} !== e.an || seg_a !== e.seg) begin
                     n_bad++;
                     $display("FAIL %s dutA: AN=%b SEG=%h expected AN=%b SEG=%h",
                              e.tag, an_a, seg_a, e.an[3:0], e.seg);
                  end
               end
               2: begin
                  n_cmp++;
                  if (rd_a !== e.rd) begin
                     n_bad++;
                     $display("FAIL %s dutA RD: got %h expected %h", e.tag, rd_a, e.rd);
                  end
               end
               3: begin
                  n_cmp++;
                  if (an_b !== e.an || seg_b !== e.seg) begin
                     n_bad++;
                     $display("FAIL %s dutB: AN=%b SEG=%h expected AN=%b SEG=%h",
                              e.tag, an_b, seg_b, e.an, e.seg);
                  end
               end
               default: ;
            endcase
         end
      end
   end

   task automatic set_a(input logic [7:0] s0, input logic [7:0] s1, input logic [7:0] s2,
                        input logic [7:0] s3, input logic [3:0] on);
      a_seg[0] = s0; a_seg[1] = s1; a_seg[2] = s2; a_seg[3] = s3;
      a_on = on;
   endtask

   task automatic reset_tables();
      set_a(8'hC0, 8'hC0, 8'hC0, 8'hC0, 4'hF);
      for (int i = 0; i < 8; i++) b_seg[i] = 8'h3F;
      ph = 0;
   endtask

   // Drive one cycle of inputs and queue the outputs expected after the coming edge.
   task automatic step(input logic rst, input logic we, input logic [1:0] addr,
                       input logic [31:0] wd, input logic chk_rd, input logic [31:0] rd_exp,
                       input string tag);
      exp_t e;
      int cnt, ia, ib;
      @(negedge CLK);
      Reset = rst;
      we_a = we; addr_a = addr; wd_a = wd;
      we_b = we_b_next; addr_b = 2'd0; wd_b = wd_b_next; we_b_next = 1'b0;
      cnt = ph % 4; ia = (ph / 4) % 4; ib = (ph / 4) % 8;
      e.tag = tag; e.rd = 32'h0;
      e.kind = 1;
      if (rst || cnt == 0 || !a_on[ia]) begin
         e.an = 8'h0F; e.seg = 8'hFF;
      end else begin
         e.an = 8'h0F & ~(8'h01 << ia); e.seg = a_seg[ia];
      end
      sb_q.push_back(e);
      e.kind = 3;
      if (rst || cnt == 0) begin
         e.an = 8'h00; e.seg = 8'h00;
      end else begin
         e.an = 8'h01 << ib; e.seg = b_seg[ib];
      end
      sb_q.push_back(e);
      if (chk_rd) begin
         e.kind = 2;
         if (addr == 2'd2) e.rd = rst ? 32'h0 : 32'(((ph + 1) / 4) % 4);
         else              e.rd = rd_exp;
         sb_q.push_back(e);
      end
      if (!rst) ph++;
   endtask

   task automatic run(input int n, input logic [1:0] addr, input logic [31:0] rd_exp,
                      input string tag);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, addr, 32'h0, 1'b1, rd_exp, tag);
   endtask

   // Assert reset between edges and check outputs/readback without waiting for a clock.
   task automatic async_rst_check();
      exp_t e;
      @(negedge CLK);
      we_a = 1'b0; addr_a = 2'd0;
      #2;
      Reset = 1'b1;
      e.tag = "async_rst"; e.rd = 32'h0;
      e.kind = 1; e.an = 8'h0F; e.seg = 8'hFF; sb_q.push_back(e);
      e.kind = 3; e.an = 8'h00; e.seg = 8'h00; sb_q.push_back(e);
      e.kind = 2; sb_q.push_back(e);
      ->mon_ev;
      #1;
   endtask

   initial begin
      Reset = 1'b1;
      we_a = 1'b0; addr_a = 2'd0; wd_a = 32'h0;
      we_b = 1'b0; addr_b = 2'd0; wd_b = 32'h0;
      we_b_next = 1'b0; wd_b_next = 32'h0;
      reset_tables();

      // Held reset: writes ignored, reset register values.
      step(1'b1, 1'b1, 2'd0, 32'h1111_1111, 1'b1, 32'h0, "rst_data");
      step(1'b1, 1'b0, 2'd1, 32'h0, 1'b1, 32'h0000_00FF, "rst_ctrl");

      // Release with the first writes on the same edge.
      we_b_next = 1'b1; wd_b_next = 32'h8765_4321;
      step(1'b0, 1'b1, 2'd0, 32'h0000_12AF, 1'b1, 32'h0000_12AF, "wr_12af");
      set_a(8'h8E, 8'h88, 8'hA4, 8'hF9, 4'hF);
      b_seg[0] = 8'h06; b_seg[1] = 8'h5B; b_seg[2] = 8'h4F; b_seg[3] = 8'h66;
      b_seg[4] = 8'h6D; b_seg[5] = 8'h7D; b_seg[6] = 8'h07; b_seg[7] = 8'h7F;
      run(40, 2'd2, 32'h0, "scan_12af");

      // Leading-zero blanking.
      step(1'b0, 1'b1, 2'd0, 32'h0000_0005, 1'b1, 32'h0000_0005, "wr_5");
      set_a(8'h92, 8'hC0, 8'hC0, 8'hC0, 4'hF);
      step(1'b0, 1'b1, 2'd1, 32'h0001_00FF, 1'b1, 32'h0001_00FF, "wr_lzb");
      set_a(8'h92, 8'hFF, 8'hFF, 8'hFF, 4'b0001);
      run(16, 2'd3, 32'h0, "lzb_5");
      step(1'b0, 1'b1, 2'd0, 32'h0, 1'b1, 32'h0, "wr_0");
      set_a(8'hC0, 8'hFF, 8'hFF, 8'hFF, 4'b0001);
      run(16, 2'd2, 32'h0, "lzb_0");

      // Digit enable: digit1 disabled, its dp stays dark.
      step(1'b0, 1'b1, 2'd1, 32'h0000_02FD, 1'b1, 32'h0000_02FD, "wr_en");
      set_a(8'hC0, 8'hFF, 8'hC0, 8'hC0, 4'b1101);
      step(1'b0, 1'b1, 2'd0, 32'h0000_1234, 1'b1, 32'h0000_1234, "wr_1234");
      set_a(8'h99, 8'hFF, 8'hA4, 8'hF9, 4'b1101);
      run(16, 2'd2, 32'h0, "en_1234");

      // Decimal points, and dp suppressed on a blanked leading zero.
      step(1'b0, 1'b1, 2'd1, 32'h0001_09FF, 1'b1, 32'h0001_09FF, "wr_dp");
      set_a(8'h19, 8'hB0, 8'hA4, 8'h79, 4'hF);
      run(8, 2'd1, 32'h0001_09FF, "dp_1234");
      step(1'b0, 1'b1, 2'd0, 32'h0000_0034, 1'b1, 32'h0000_0034, "wr_34");
      set_a(8'h19, 8'hB0, 8'hFF, 8'hFF, 4'b0011);
      run(16, 2'd2, 32'h0, "dp_lzb");

      // Readback and read-only registers.
      step(1'b0, 1'b1, 2'd0, 32'hDEAD_BEEF, 1'b1, 32'hDEAD_BEEF, "wr_dead");
      set_a(8'h0E, 8'h86, 8'h86, 8'h03, 4'hF);
      step(1'b0, 1'b1, 2'd1, 32'hFFFF_FFFF, 1'b1, 32'h0001_FFFF, "wr_ctrl_ff");
      set_a(8'h0E, 8'h06, 8'h06, 8'h03, 4'hF);
      step(1'b0, 1'b0, 2'd0, 32'h0, 1'b1, 32'hDEAD_BEEF, "rd_data");
      step(1'b0, 1'b1, 2'd2, 32'h0000_0007, 1'b1, 32'h0, "wr_stat");
      step(1'b0, 1'b1, 2'd3, 32'hFFFF_FFFF, 1'b1, 32'h0, "wr_rsvd");
      step(1'b0, 1'b0, 2'd0, 32'h0, 1'b1, 32'hDEAD_BEEF, "rd_data2");
      run(16, 2'd2, 32'h0, "rd_idx");

      // Asynchronous reset in digit2, slot cycle 3.
      while ((ph % 16) != 11) step(1'b0, 1'b0, 2'd2, 32'h0, 1'b1, 32'h0, "pre_rst");
      async_rst_check();
      reset_tables();
      step(1'b1, 1'b0, 2'd1, 32'h0, 1'b1, 32'h0000_00FF, "rst2_ctrl");
      step(1'b0, 1'b0, 2'd0, 32'h0, 1'b1, 32'h0, "rel_data");
      run(16, 2'd2, 32'h0, "post_rst");

      @(posedge CLK);
      #3;
      if (sb_q.size() != 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL sb_drain: %0d entries left, expected 0", sb_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/seg_scan_driver.md
Name: seg_scan_driver

Overview:
- Memory-mapped, multiplexed seven-segment display controller. Parametrised successor to the single 32-bit latched segment register.
- Holds a 32-bit hex value plus a control word written by the processor store path. Time-multiplexes up to 8 digits with a programmable refresh rate and an anti-ghosting blank window.
- Adds leading-zero blanking, per-digit enable, per-digit decimal point and readback.

Parameters:
- DIGITS, 8, number of digits scanned; legal range 1..8; digit i displays WD nibble [4i+3:4i].
- DIV, 100000, CLK cycles per digit slot; must be >= 2.
- BLANK, 8, cycles at the start of each slot with all anodes and segments off; must be < DIV.
- ACTIVE_LOW, 1, 1: AN and SEG are active-low (off = all ones); 0: active-high.

Ports:
- CLK, input, 1, system clock.
- Reset, input, 1, asynchronous, active-high reset.
- WE, input, 1, write strobe; sampled on rising CLK edge.
- ADDR, input, 2, register select: 0 DATA, 1 CTRL, 2 STATUS (read-only), 3 reserved.
- WD, input, 32, write data.
- RD, output, 32, combinational readback of register selected by ADDR.
- AN, output, DIGITS, digit anode selects, registered.
- SEG, output, 8, {dp,g,f,e,d,c,b,a}, registered.

Behaviour:
- Reset (asynchronous, active-high; clock CLK):
  - DATA = 0.
  - CTRL = 32'h000000FF (all digits enabled, no dp, LZB off).
  - Prescaler cnt = 0, digit index idx = 0.
  - AN and SEG = off value (all ones if ACTIVE_LOW, else zeros).
  - Reset mid-slot aborts the scan; scanning restarts at digit 0, cnt 0 after release.
- Writes:
  - WE=1 with ADDR=0 loads DATA; with ADDR=1 loads CTRL bits [16:0]. CTRL[31:17] reads 0.
  - Writes to ADDR 2/3 are ignored.
  - New values affect outputs from the next output-register update.
- CTRL fields:
  - [7:0] EN: digit enable; bits >= DIGITS are ignored.
  - [15:8] DP: dp lit for digit i.
  - [16] LZB: leading-zero blanking.
- RD: ADDR 0 -> DATA; 1 -> CTRL; 2 -> {29'b0, idx[2:0]}; 3 -> 0. No side effects.
- Prescaler and scan:
  - cnt counts 0..DIV-1 every cycle. At cnt==DIV-1, cnt wraps to 0 and idx advances (idx==DIGITS-1 -> 0).
  - One full frame = DIGITS*DIV cycles.
- Output register, updated every cycle from the current cnt, idx, DATA and CTRL (1-cycle latency):
  - If cnt < BLANK -> AN, SEG off.
  - Else if EN[idx]=0 -> AN, SEG off.
  - Else if LZB=1 and idx != 0 and DATA nibbles idx..DIGITS-1 are all zero -> AN, SEG off.
  - Else only AN[idx] is active; SEG[6:0] = hex pattern of nibble idx; SEG[7] = DP[idx].
  - A dp on a blanked leading-zero digit is also suppressed.
- Hex patterns, active-high {g..a}: 0 3F, 1 06, 2 5B, 3 4F, 4 66, 5 6D, 6 7D, 7 07, 8 7F, 9 6F, A 77, b 7C, C 39, d 5E, E 79, F 71.
- ACTIVE_LOW=1 inverts both AN and SEG at the output register.
- At most one AN bit is active in any cycle.
- A write landing in the same cycle as a slot wrap is applied; the new slot shows the new value one cycle after the write.
- DIGITS=1: idx stays 0; the blank window still applies each slot.

Test Plan:
- DIGITS=4, DIV=4, BLANK=1, ACTIVE_LOW=1. Write DATA=32'h0000_12AF, no other writes. Cycle 1 of each slot -> AN=4'b1111, SEG=8'hFF. Cycles 2-4 of each slot:
  - digit0: AN=1110, SEG=8'h8E.
  - digit1: AN=1101, SEG=8'h88.
  - digit2: AN=1011, SEG=8'hA4.
  - digit3: AN=0111, SEG=8'hF9.
  - idx sequence 0,1,2,3,0, period 16 cycles.
- Write CTRL=32'h0001_00FF with DATA=32'h0000_0005 -> digits 1..3 fully off (AN bit high); digit0 shows SEG=8'h92. DATA=0 -> digit0 shows '0', SEG=8'hC0.
- CTRL=32'h0000_02FD, DATA=32'h0000_1234 -> digit1 never active. Digit1 has dp set but is disabled, so dp is not lit. Other digits shown normally.
- Assert Reset during digit2 slot cycle 3 -> AN=1111, SEG=FF immediately (asynchronous). DATA reads 0, CTRL reads 0x000000FF. After release, first active digit is digit0 at cycle BLANK+1.
- Readback: write DATA=32'hDEADBEEF, CTRL=32'hFFFF_FFFF -> RD(ADDR0)=DEADBEEF, RD(ADDR1)=0001FFFF. RD(ADDR2) tracks idx. RD(ADDR3)=0. A write to ADDR2 does not change idx.
- ACTIVE_LOW=0, DIGITS=8, DATA=32'h8765_4321 -> AN one-hot active-high; digit7 SEG=8'h7F. Exactly one AN bit is set during every non-blank cycle over 2 frames.
